// File: rtl/data_array_write_arbiter.sv
// Four-requester, two-port write arbiter for a data array: per-requester holding registers,
// round-robin grant of up to two writes per cycle. Optional DATA_ARRAY_WRITE_COLLISION_CHECK_EN.
module data_array_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int ENTRIES   = 16,
  parameter int DATA_W    = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_0_valid,
  output logic              io_req_0_ready,
  input  logic [ENTRIES-1:0] io_req_0_addr,
  input  logic [DATA_W-1:0] io_req_0_data,
  input  logic              io_req_1_valid,
  output logic              io_req_1_ready,
  input  logic [ENTRIES-1:0] io_req_1_addr,
  input  logic [DATA_W-1:0] io_req_1_data,
  input  logic              io_req_2_valid,
  output logic              io_req_2_ready,
  input  logic [ENTRIES-1:0] io_req_2_addr,
  input  logic [DATA_W-1:0] io_req_2_data,
  input  logic              io_req_3_valid,
  output logic              io_req_3_ready,
  input  logic [ENTRIES-1:0] io_req_3_addr,
  input  logic [DATA_W-1:0] io_req_3_data,
  input  logic              io_stall,
  output logic              io_wport_0_enable,
  output logic [ENTRIES-1:0] io_wport_0_addr,
  output logic [DATA_W-1:0] io_wport_0_data,
  output logic              io_wport_1_enable,
  output logic [ENTRIES-1:0] io_wport_1_addr,
  output logic [DATA_W-1:0] io_wport_1_data,
  output logic              io_pending
);
  localparam int IDX_W = $clog2(NUM_REQ);

  // The port list is hand-written for exactly four requesters and two ports.
  if (NUM_REQ != 4 || NUM_PORTS != 2) begin : g_bad_cfg
    $error("data_array_write_arbiter supports only NUM_REQ=4, NUM_PORTS=2");
  end

  // Handshake: requester i's write is taken at the edge when valid and ready are both high;
  // ready is high when its holding register is empty or is being granted this cycle.
  logic [NUM_REQ-1:0] req_valid, ready, accept, hold_valid, grant;
  logic [ENTRIES-1:0] req_addr [NUM_REQ];
  logic [ENTRIES-1:0] hold_addr [NUM_REQ];
  logic [DATA_W-1:0]  req_data [NUM_REQ];
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic [IDX_W-1:0]   rr, rr_next, g0_idx, g1_idx, scan_idx;
  logic               g0_hit, g1_hit, second_seen, collide;

  assign req_valid   = {io_req_3_valid, io_req_2_valid, io_req_1_valid, io_req_0_valid};
  assign req_addr[0] = io_req_0_addr;
  assign req_addr[1] = io_req_1_addr;
  assign req_addr[2] = io_req_2_addr;
  assign req_addr[3] = io_req_3_addr;
  assign req_data[0] = io_req_0_data;
  assign req_data[1] = io_req_1_data;
  assign req_data[2] = io_req_2_data;
  assign req_data[3] = io_req_3_data;

  assign ready  = ~hold_valid | grant;
  assign accept = req_valid & ready;
  assign {io_req_3_ready, io_req_2_ready, io_req_1_ready, io_req_0_ready} = ready;
  assign io_pending = |hold_valid;

  // Scan from rr with wrap; only the first two valid holders are candidates.
  always_comb begin
    g0_hit      = 1'b0;
    g1_hit      = 1'b0;
    g0_idx      = '0;
    g1_idx      = '0;
    second_seen = 1'b0;
    scan_idx    = '0;
    collide     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(rr) + k) % NUM_REQ);
      if (hold_valid[scan_idx] && !io_stall) begin
        if (!g0_hit) begin
          g0_hit = 1'b1;
          g0_idx = scan_idx;
        end else if (!second_seen) begin
          second_seen = 1'b1;
`ifdef DATA_ARRAY_WRITE_COLLISION_CHECK_EN
          collide = |(hold_addr[g0_idx] & hold_addr[scan_idx]);
`else
          collide = 1'b0;
`endif
          if (!collide) begin
            g1_hit = 1'b1;
            g1_idx = scan_idx;
          end
        end
      end
    end
    grant = '0;
    if (g0_hit) grant[g0_idx] = 1'b1;
    if (g1_hit) grant[g1_idx] = 1'b1;
    rr_next = rr;
    if (g1_hit)      rr_next = IDX_W'((int'(g1_idx) + 1) % NUM_REQ);
    else if (g0_hit) rr_next = IDX_W'((int'(g0_idx) + 1) % NUM_REQ);
  end

  // A granted holder that accepts in the same cycle stays valid with the new write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid <= '0;
      rr         <= '0;
    end else begin
      rr <= rr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i])     hold_valid[i] <= 1'b1;
        else if (grant[i]) hold_valid[i] <= 1'b0;
      end
    end
  end

  // Payload is qualified by hold_valid, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        hold_addr[i] <= req_addr[i];
        hold_data[i] <= req_data[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_wport_0_enable <= 1'b0;
      io_wport_0_addr   <= '0;
      io_wport_0_data   <= '0;
      io_wport_1_enable <= 1'b0;
      io_wport_1_addr   <= '0;
      io_wport_1_data   <= '0;
    end else begin
      io_wport_0_enable <= g0_hit;
      io_wport_1_enable <= g1_hit;
      if (g0_hit) begin
        io_wport_0_addr <= hold_addr[g0_idx];
        io_wport_0_data <= hold_data[g0_idx];
      end
      if (g1_hit) begin
        io_wport_1_addr <= hold_addr[g1_idx];
        io_wport_1_data <= hold_data[g1_idx];
      end
    end
  end
endmodule

// File: tb/tb_data_array_write_arbiter.sv
// Directed bench for data_array_write_arbiter; expectations follow DATA_ARRAY_WRITE_COLLISION_CHECK_EN.
module tb_data_array_write_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid [4];
  logic        ready [4];
  logic [15:0] addr [4];
  logic [63:0] data [4];
  logic        stall;
  logic        en0, en1, pending;
  logic [15:0] a0, a1;
  logic [63:0] d0, d1;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  data_array_write_arbiter dut (
    .clock(clock), .reset(reset),
    .io_req_0_valid(valid[0]), .io_req_0_ready(ready[0]), .io_req_0_addr(addr[0]), .io_req_0_data(data[0]),
    .io_req_1_valid(valid[1]), .io_req_1_ready(ready[1]), .io_req_1_addr(addr[1]), .io_req_1_data(data[1]),
    .io_req_2_valid(valid[2]), .io_req_2_ready(ready[2]), .io_req_2_addr(addr[2]), .io_req_2_data(data[2]),
    .io_req_3_valid(valid[3]), .io_req_3_ready(ready[3]), .io_req_3_addr(addr[3]), .io_req_3_data(data[3]),
    .io_stall(stall),
    .io_wport_0_enable(en0), .io_wport_0_addr(a0), .io_wport_0_data(d0),
    .io_wport_1_enable(en1), .io_wport_1_addr(a1), .io_wport_1_data(d1),
    .io_pending(pending)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [63:0] d);
    valid[i] = v;
    addr[i]  = a;
    data[i]  = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'h0, 64'h0);
  endtask

  task automatic apply_reset();
    idle_all();
    stall = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    idle_all();
    stall = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_en0", en0, 1'b0);
    check("rst_en1", en1, 1'b0);
    check("rst_addr0", a0, 16'h0);
    check("rst_data1", d1, 64'h0);
    check("rst_pending", pending, 1'b0);
    step();
    reset = 1'b0;
    step();

    // Single uncontended write: two-cycle latency, port 0 only.
    set_req(0, 1'b1, 16'h0001, 64'hA5);
    step();
    idle_all();
    check("lat_en0_early", en0, 1'b0);
    check("lat_pending", pending, 1'b1);
    step();
    check("lat_en0", en0, 1'b1);
    check("lat_addr0", a0, 16'h0001);
    check("lat_data0", d0, 64'hA5);
    check("lat_en1", en1, 1'b0);
    step();
    check("lat_en0_off", en0, 1'b0);
    check("lat_addr0_keep", a0, 16'h0001);
    check("lat_data0_keep", d0, 64'hA5);
    check("lat_pending_off", pending, 1'b0);

    // All four requesters valid continuously: pairs (0,1),(2,3),(0,1),(2,3),(0,1).
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'(1 << i), 64'(256 + i));
    step();
    check("rr_ready0", ready[0], 1'b1);
    check("rr_ready2", ready[2], 1'b0);
    step();
    check("rr_p0_a", a0, 16'h0001);
    check("rr_p1_a", a1, 16'h0002);
    check("rr_en_a", {en0, en1}, 2'b11);
    step();
    check("rr_p0_b", a0, 16'h0004);
    check("rr_p1_b", a1, 16'h0008);
    check("rr_d1_b", d1, 64'h103);
    step();
    check("rr_p0_c", a0, 16'h0001);
    check("rr_p1_c", a1, 16'h0002);
    idle_all();
    step();
    check("rr_p0_d", a0, 16'h0004);
    check("rr_p1_d", a1, 16'h0008);
    step();
    check("rr_p0_e", a0, 16'h0001);
    check("rr_en_e", {en0, en1}, 2'b11);
    step();
    check("rr_drained_en", {en0, en1}, 2'b00);
    check("rr_drained_pend", pending, 1'b0);

    // Stall for three cycles with two held writes.
    apply_reset();
    stall = 1'b1;
    set_req(0, 1'b1, 16'h0100, 64'h11);
    set_req(1, 1'b1, 16'h0200, 64'h22);
    step();
    idle_all();
    for (int c = 0; c < 3; c++) begin
      check("stall_ready0", ready[0], 1'b0);
      check("stall_ready1", ready[1], 1'b0);
      step();
      check("stall_en", {en0, en1}, 2'b00);
    end
    stall = 1'b0;
    #1;
    check("unstall_ready0", ready[0], 1'b1);
    step();
    check("unstall_en", {en0, en1}, 2'b11);
    check("unstall_d0", d0, 64'h11);
    check("unstall_d1", d1, 64'h22);

    // Requesters 1 and 2 target the same entry.
    apply_reset();
    set_req(1, 1'b1, 16'h0010, 64'hB1);
    set_req(2, 1'b1, 16'h0010, 64'hB2);
    step();
    idle_all();
    step();
    check("col_en0", en0, 1'b1);
    check("col_d0", d0, 64'hB1);
`ifdef DATA_ARRAY_WRITE_COLLISION_CHECK_EN
    check("col_en1", en1, 1'b0);
    check("col_pending", pending, 1'b1);
    step();
    check("col_en0_next", en0, 1'b1);
    check("col_d0_next", d0, 64'hB2);
    check("col_en1_next", en1, 1'b0);
`else
    check("col_en1", en1, 1'b1);
    check("col_d1", d1, 64'hB2);
    check("col_a1", a1, 16'h0010);
    step();
    check("col_en_next", {en0, en1}, 2'b00);
`endif
    step();
    check("col_pending_end", pending, 1'b0);

    // Reset while three holding registers are full.
    apply_reset();
    stall = 1'b1;
    set_req(0, 1'b1, 16'h0001, 64'hC0);
    set_req(1, 1'b1, 16'h0002, 64'hC1);
    set_req(2, 1'b1, 16'h0004, 64'hC2);
    step();
    idle_all();
    check("mid_pending", pending, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_pending", pending, 1'b0);
    #2;
    reset = 1'b0;
    stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check("mid_ready", ready[i], 1'b1);
    step();
    check("mid_en_a", {en0, en1}, 2'b00);
    step();
    check("mid_en_b", {en0, en1}, 2'b00);
    check("mid_pending_after", pending, 1'b0);

    // Back-to-back writes from requester 3 stay in order.
    apply_reset();
    set_req(3, 1'b1, 16'h8000, 64'h1);
    step();
    check("b2b_ready3", ready[3], 1'b1);
    set_req(3, 1'b1, 16'h8000, 64'h2);
    step();
    check("b2b_d0_1", d0, 64'h1);
    check("b2b_en0_1", en0, 1'b1);
    set_req(3, 1'b1, 16'h8000, 64'h3);
    step();
    check("b2b_d0_2", d0, 64'h2);
    check("b2b_en0_2", en0, 1'b1);
    idle_all();
    step();
    check("b2b_d0_3", d0, 64'h3);
    check("b2b_en_3", {en0, en1}, 2'b10);
    step();
    check("b2b_done", en0, 1'b0);

    // All-zero address is still arbitrated as a write.
    apply_reset();
    set_req(2, 1'b1, 16'h0000, 64'h77);
    step();
    idle_all();
    step();
    check("zero_en0", en0, 1'b1);
    check("zero_addr0", a0, 16'h0000);
    check("zero_data0", d0, 64'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_array_write_arbiter.md
DATA_ARRAY_WRITE_ARBITER -- requirements
Module: data_array_write_arbiter

Interface
- REQ-001: Parameter NUM_REQ, 4, number of write requesters.
- REQ-002: Parameter NUM_PORTS, 2, number of data-array write ports driven; only 2 is supported.
- REQ-003: Parameter ENTRIES, 16, width of the one-hot entry address vector.
- REQ-004: Parameter DATA_W, 64, write data width.
- REQ-005: clock  input  1  sole clock; all state updates on the rising edge.
- REQ-006: reset  input  1  asynchronous, active-high reset.
- REQ-007: io_req_<i>_valid  input  1  requester i (i=0..NUM_REQ-1) offers a write.
- REQ-008: io_req_<i>_ready  output  1  requester i's write is accepted this cycle when valid is also high.
- REQ-009: io_req_<i>_addr  input  ENTRIES  one-hot target entry vector.
- REQ-010: io_req_<i>_data  input  DATA_W  write data.
- REQ-011: io_stall  input  1  blocks all grants this cycle.
- REQ-012: io_wport_<j>_enable  output  1  registered write enable to data-array port j (j=0,1).
- REQ-013: io_wport_<j>_addr  output  ENTRIES  registered one-hot address for port j.
- REQ-014: io_wport_<j>_data  output  DATA_W  registered data for port j.
- REQ-015: io_pending  output  1  OR of all holding-register valid bits.

Function
- REQ-016: Each requester SHALL own one holding register (valid, addr, data); an accepted write (valid & ready) SHALL be loaded into it at the next edge.
- REQ-017: io_req_<i>_ready SHALL be high when holding i is empty or holding i is granted this cycle; a granted write and a new accept in the same cycle SHALL leave holding i valid with the new write.
- REQ-018: Each cycle with io_stall=0, the arbiter SHALL grant up to 2 valid holding registers, scanning from round-robin pointer rr upward with wrap-around modulo NUM_REQ.
- REQ-019: The first grant SHALL drive port 0 and the second grant SHALL drive port 1 at the next edge.
- REQ-020: Port registers SHALL load enable=1 with the granted addr and data; an ungranted port SHALL load enable=0 and keep its previous addr and data.
- REQ-021: Latency from accept at cycle t to io_wport enable SHALL be exactly 2 cycles when uncontended and io_stall=0.
- REQ-022: rr SHALL advance to (last granted index + 1) mod NUM_REQ; it SHALL hold when nothing is granted.
- REQ-023: While io_stall=1, the arbiter SHALL make no grants, SHALL drive both port enables to 0 at the next edge, SHALL keep holding contents, and SHALL keep ready low for every full holding register.
- REQ-024: Writes from one requester SHALL reach the ports in acceptance order; no write SHALL be dropped or duplicated.
- REQ-025: An all-zero addr SHALL be treated as a legal write with no effect and SHALL be arbitrated normally.

Reset
- REQ-026: On reset assertion, the block SHALL immediately clear all holding valid bits, set rr=0, and clear both port enables, addrs and datas to 0; io_pending SHALL be 0.
- REQ-027: Reset asserted mid-operation SHALL discard held writes without producing a port enable; every ready SHALL be 1 in the first cycle after deassertion.

Configuration
- REQ-028: With macro DATA_ARRAY_WRITE_COLLISION_CHECK_EN defined, the second candidate SHALL NOT be granted when (first addr & second addr) is non-zero; it SHALL stay held and compete again next cycle, and rr SHALL advance past the first grant only.
- REQ-029: Without DATA_ARRAY_WRITE_COLLISION_CHECK_EN, the collision check SHALL be absent and both candidates SHALL be granted regardless of address overlap.

Verification
- REQ-030: After reset, requester 0 presents addr=0x0001, data=0xA5 at cycle 1 -> io_wport_0_enable=1, addr 0x0001, data 0xA5 at cycle 3; port 1 enable stays 0.
- REQ-031: All 4 requesters are valid continuously from rr=0 -> grant pairs are (0,1), (2,3), (0,1), ..., with rr cycling 0, 2, 0.
- REQ-032: io_stall=1 for 3 cycles while 2 writes are held -> port enables stay 0 and readies stay low; stall drops -> both writes emerge the next cycle.
- REQ-033: Requesters 1 and 2 both target addr 0x0010 -> with the macro, req1 is on port 0 and req2 is on port 0 one cycle later; without the macro, both ports are enabled in the same cycle.
- REQ-034: Reset is pulsed while 3 holding registers are valid -> no port enable follows, io_pending=0, and all readies are 1 after deassertion.
- REQ-035: Requester 3 back-to-back accepts data 1, 2, 3 with no stall -> port writes carry 1, 2, 3 in order on consecutive cycles.
